// File: rtl/tune_sequencer_if.sv
// ============================================================================
//  Module   : tune_sequencer_if
//  Function : Request, control and status bundle between the robot event
//             logic and the tune sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tune_sequencer_if;
    logic       fault_req;
    logic       low_batt_req;
    logic       tour_done_req;
    logic       mute;
    logic       go;
    logic       busy;
    logic [1:0] tune_id;
    logic [7:0] play_cnt;

    modport master (
        output fault_req, low_batt_req, tour_done_req, mute,
        input  go, busy, tune_id, play_cnt
    );

    modport slave (
        input  fault_req, low_batt_req, tour_done_req, mute,
        output go, busy, tune_id, play_cnt
    );
endinterface

`default_nettype wire

// File: rtl/tune_sequencer.sv
// ============================================================================
//  Module   : tune_sequencer
//  Function : Prioritised tune request queue that pulses the piezo player,
//             times each playback and enforces a silent gap between tunes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tune_sequencer #(
    parameter bit          FAST_SIM     = 1'b1,
    parameter logic [31:0] PLAY_CYCLES  = 32'd71303184,
    parameter logic [31:0] GAP_CYCLES   = 32'd2500000,
    parameter int unsigned FAULT_REPEAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    tune_sequencer_if.slave   sif
);

    // Zero-length play/gap would underflow the timer load, so clamp to 1.
    localparam logic [31:0] c_play_raw = FAST_SIM ? (PLAY_CYCLES >> 4) : PLAY_CYCLES;
    localparam logic [31:0] c_play_eff = (c_play_raw == 32'd0) ? 32'd1 : c_play_raw;
    localparam logic [31:0] c_gap_eff  = (GAP_CYCLES == 32'd0) ? 32'd1 : GAP_CYCLES;
    localparam logic [2:0]  c_rep_load = 3'(FAULT_REPEAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  rep_q,   rep_d;
    logic [2:0]  pend_q,  pend_d;   // bit0 fault, bit1 low_batt, bit2 tour_done
    logic [2:0]  prev_q,  prev_d;
    logic [1:0]  tune_q,  tune_d;
    logic [7:0]  cnt_q,   cnt_d;

    logic [2:0]  w_req;
    logic [2:0]  w_edge;
    logic [2:0]  w_clear;
    logic [2:0]  w_win_mask;
    logic [1:0]  w_win_id;
    logic        w_any;
    logic        w_grant;

    always_comb begin
        w_req      = {sif.tour_done_req, sif.low_batt_req, sif.fault_req};
        w_edge     = w_req & ~prev_q;
        prev_d     = w_req;
        w_any      = (|pend_q) && !sif.mute;

        if (pend_q[0]) begin
            w_win_id   = 2'd1;
            w_win_mask = 3'b001;
        end else if (pend_q[1]) begin
            w_win_id   = 2'd2;
            w_win_mask = 3'b010;
        end else begin
            w_win_id   = 2'd3;
            w_win_mask = 3'b100;
        end

        state_d = state_q;
        timer_d = timer_q;
        rep_d   = rep_q;
        tune_d  = tune_q;
        cnt_d   = cnt_q;
        w_grant = 1'b0;
        w_clear = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    state_d = S_START;
                    w_grant = 1'b1;
                end
            end
            S_START: begin
                cnt_d   = cnt_q + 8'd1;
                timer_d = c_play_eff - 32'd1;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (timer_q == 32'd0) begin
                    timer_d = c_gap_eff - 32'd1;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_GAP: begin
                if (timer_q != 32'd0) begin
                    timer_d = timer_q - 32'd1;
                end else if ((rep_q != 3'd0) && !sif.mute) begin
                    // Fault repeats replay without consuming a pending flag.
                    rep_d   = rep_q - 3'd1;
                    tune_d  = 2'd1;
                    state_d = S_START;
                end else if (w_any) begin
                    state_d = S_START;
                    w_grant = 1'b1;
                end else begin
                    tune_d  = 2'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_grant) begin
            w_clear = w_win_mask;
            tune_d  = w_win_id;
            if (w_win_id == 2'd1) begin
                rep_d = c_rep_load;
            end
        end

        // A new edge in the cycle its flag is cleared keeps the flag set.
        pend_d = sif.mute ? 3'b000 : ((pend_q & ~w_clear) | w_edge);
        if (sif.mute) begin
            rep_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= 32'd0;
            rep_q   <= 3'd0;
            pend_q  <= 3'b000;
            prev_q  <= 3'b111;
            tune_q  <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rep_q   <= rep_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            tune_q  <= tune_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sif.go       = (state_q == S_START);
    assign sif.busy     = (state_q != S_IDLE);
    assign sif.tune_id  = tune_q;
    assign sif.play_cnt = cnt_q;

endmodule

`default_nettype wire
